// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline sequencer: FSM states,
// register-address width and the per-stage control bundle.
package pipeline_ctrl_pkg;

  localparam int REG_W        = 5;
  localparam int WAIT_W       = 8;
  localparam int DEF_MAX_WAIT = 16;
  localparam int DEF_CNT_W    = 16;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT     = 2'd3;

  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_write;
    logic exmem_flush;
    logic memwb_bubble;
  } ctrl_t;

  // Whole pipeline parked: nothing advances and control-zero enters ID/EX and MEM/WB.
  localparam ctrl_t CTRL_IDLE      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_MEM_STALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_BRANCH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_LOAD_USE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_ADVANCE   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline sequencer (master) and the datapath/memory side (slave).
interface pipeline_ctrl_if #(
  parameter int CNT_W = pipeline_ctrl_pkg::DEF_CNT_W
);
  import pipeline_ctrl_pkg::*;

  logic             start_i;
  logic             IDEX_MemRead_i;
  logic [REG_W-1:0] IDEX_RDaddr_i;
  logic [REG_W-1:0] IFID_RS1addr_i;
  logic [REG_W-1:0] IFID_RS2addr_i;
  logic             EXMEM_Branch_i;
  logic             EXMEM_Zero_i;
  logic             EXMEM_MemRead_i;
  logic             EXMEM_MemWrite_i;
  logic             mem_ack_i;
  logic             mem_req_o;
  logic             PCWrite_o;
  logic             PCSrc_o;
  logic             IFID_Write_o;
  logic             IFID_Flush_o;
  logic             IDEX_Bubble_o;
  logic             EXMEM_Write_o;
  logic             EXMEM_Flush_o;
  logic             MEMWB_Bubble_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    input  start_i, IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
           EXMEM_Branch_i, EXMEM_Zero_i, EXMEM_MemRead_i, EXMEM_MemWrite_i, mem_ack_i,
    output mem_req_o, PCWrite_o, PCSrc_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o,
           EXMEM_Write_o, EXMEM_Flush_o, MEMWB_Bubble_o, timeout_o, stall_cnt_o
  );

  modport slave (
    output start_i, IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
           EXMEM_Branch_i, EXMEM_Zero_i, EXMEM_MemRead_i, EXMEM_MemWrite_i, mem_ack_i,
    input  mem_req_o, PCWrite_o, PCSrc_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o,
           EXMEM_Write_o, EXMEM_Flush_o, MEMWB_Bubble_o, timeout_o, stall_cnt_o
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: a load in ID/EX whose destination feeds the instruction in IF/ID.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  output logic             stall_lu
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign stall_lu = idex_mem_read && (idex_rd != '0) &&
                    ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline registers: arbitrates memory stalls,
// taken branches and load-use hazards into per-stage enable/flush/bubble controls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipeline_ctrl_if.master      bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  logic [1:0]        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              timeout_q, timeout_set;
  logic [CNT_W-1:0]  stall_cnt;
  logic              active, memop, mem_stall, branch_taken, stall_lu;
  ctrl_t             ctrl;

  hazard_detect u_hazard_detect (
    .idex_mem_read (bus.IDEX_MemRead_i),
    .idex_rd       (bus.IDEX_RDaddr_i),
    .ifid_rs1      (bus.IFID_RS1addr_i),
    .ifid_rs2      (bus.IFID_RS2addr_i),
    .stall_lu      (stall_lu)
  );

  assign active       = !rst_i && ((state == ST_RUN) || (state == ST_MEM_WAIT));
  assign memop        = bus.EXMEM_MemRead_i || bus.EXMEM_MemWrite_i;
  assign mem_stall    = memop && !bus.mem_ack_i;
  assign branch_taken = bus.EXMEM_Branch_i && bus.EXMEM_Zero_i;

  // NOTE: every always_comb output gets a default up front so no path infers a latch.
  always_comb begin
    ctrl          = CTRL_IDLE;
    bus.mem_req_o = 1'b0;
    if (active) begin
      bus.mem_req_o = memop;
      if (mem_stall)         ctrl = CTRL_MEM_STALL;
      else if (branch_taken) ctrl = CTRL_BRANCH;
      else if (stall_lu)     ctrl = CTRL_LOAD_USE;
      else                   ctrl = CTRL_ADVANCE;
    end
  end

  assign bus.PCWrite_o      = ctrl.pc_write;
  assign bus.PCSrc_o        = ctrl.pc_src;
  assign bus.IFID_Write_o   = ctrl.ifid_write;
  assign bus.IFID_Flush_o   = ctrl.ifid_flush;
  assign bus.IDEX_Bubble_o  = ctrl.idex_bubble;
  assign bus.EXMEM_Write_o  = ctrl.exmem_write;
  assign bus.EXMEM_Flush_o  = ctrl.exmem_flush;
  assign bus.MEMWB_Bubble_o = ctrl.memwb_bubble;
  assign bus.timeout_o      = timeout_q;
  assign bus.stall_cnt_o    = stall_cnt;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;
    case (state)
      ST_IDLE: if (bus.start_i) state_nxt = ST_RUN;
      ST_RUN: begin
        if (mem_stall) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        // An ack releases in the same cycle; otherwise give up once the budget is spent.
        if (!mem_stall) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_nxt   = ST_HALT;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      timeout_q <= timeout_q || timeout_set;
      if (active && !ctrl.pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: the stimulus thread queues hand-computed expectations
// per cycle and a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  // Control vector order: {PCWrite, PCSrc, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Write, EXMEM_Flush, MEMWB_Bubble}
  localparam logic [7:0] V_IDLE = 8'b0000_1001;
  localparam logic [7:0] V_RUN  = 8'b1010_0100;
  localparam logic [7:0] V_LU   = 8'b0000_1100;
  localparam logic [7:0] V_BR   = 8'b1111_1110;
  localparam logic [7:0] V_MS   = 8'b0000_0001;
  localparam logic [7:0] M_ALL  = 8'hFF;
  localparam logic [7:0] M_BR   = 8'b1101_1011;
  localparam logic [7:0] M_MS   = 8'b1110_0101;

  typedef struct {
    string       name;
    logic [7:0]  ctrl;
    logic [7:0]  mask;
    logic        req;
    logic [15:0] stall;
    logic        to;
  } exp_t;

  logic clk = 1'b1;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(16)) bus ();

  pipeline_ctrl #(.MAX_WAIT(4), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, st, idex_mr, input logic [4:0] rd, rs1, rs2,
                       input logic br, zero, mr, mw, ack);
    rst                  = r;
    bus.start_i          = st;
    bus.IDEX_MemRead_i   = idex_mr;
    bus.IDEX_RDaddr_i    = rd;
    bus.IFID_RS1addr_i   = rs1;
    bus.IFID_RS2addr_i   = rs2;
    bus.EXMEM_Branch_i   = br;
    bus.EXMEM_Zero_i     = zero;
    bus.EXMEM_MemRead_i  = mr;
    bus.EXMEM_MemWrite_i = mw;
    bus.mem_ack_i        = ack;
  endtask

  task automatic exp_cycle(input string name, input logic [7:0] ctrl, mask, input logic req,
                           input logic [15:0] stall, input logic to);
    exp_t e;
    e.name = name; e.ctrl = ctrl; e.mask = mask; e.req = req; e.stall = stall; e.to = to;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t       e;
      logic [7:0] act;
      e   = q.pop_front();
      act = {bus.PCWrite_o, bus.PCSrc_o, bus.IFID_Write_o, bus.IFID_Flush_o,
             bus.IDEX_Bubble_o, bus.EXMEM_Write_o, bus.EXMEM_Flush_o, bus.MEMWB_Bubble_o};
      check({e.name, "/ctrl"},    16'(act & e.mask), 16'(e.ctrl & e.mask));
      check({e.name, "/mem_req"}, 16'(bus.mem_req_o), 16'(e.req));
      check({e.name, "/stall"},   bus.stall_cnt_o, e.stall);
      check({e.name, "/timeout"}, 16'(bus.timeout_o), 16'(e.to));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // args: rst start idex_mr rd rs1 rs2 br zero mr mw ack
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_cycle("reset",          V_IDLE, M_ALL, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("reset_memop",    V_IDLE, M_ALL, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_cycle("idle_start",     V_IDLE, M_ALL, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_cycle("run_none",       V_RUN,  M_ALL, 0, 0, 0);
    drive(0, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0); exp_cycle("lu_rs1",         V_LU,   M_ALL, 0, 0, 0);
    drive(0, 0, 1, 7, 3, 7, 0, 0, 0, 0, 0); exp_cycle("lu_rs2",         V_LU,   M_ALL, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); exp_cycle("lu_rd_zero",     V_RUN,  M_ALL, 0, 2, 0);
    drive(0, 0, 1, 5, 5, 0, 1, 1, 0, 0, 0); exp_cycle("branch_over_lu", V_BR,   M_BR,  0, 2, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); exp_cycle("branch_not_tkn", V_RUN,  M_ALL, 0, 2, 0);

    // Load acked on its fourth request cycle.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("memwait_c1",     V_MS,   M_MS,  1, 2, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("memwait_c2",     V_MS,   M_MS,  1, 3, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("memwait_c3",     V_MS,   M_MS,  1, 4, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1); exp_cycle("memwait_ack",    V_RUN,  M_ALL, 1, 5, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); exp_cycle("zero_latency",   V_RUN,  M_ALL, 1, 5, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); exp_cycle("ack_no_req",     V_RUN,  M_ALL, 0, 5, 0);

    // Release from MEM_WAIT in the same cycle as a taken branch.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("stall_pre_br",   V_MS,   M_MS,  1, 5, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1); exp_cycle("ack_with_br",    V_BR,   M_BR,  1, 6, 0);

    // Never acked: one RUN stall cycle then four MEM_WAIT cycles before HALT.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("to_run",         V_MS,   M_MS,  1, 6, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("to_wait1",       V_MS,   M_MS,  1, 7, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("to_wait2",       V_MS,   M_MS,  1, 8, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("to_wait3",       V_MS,   M_MS,  1, 9, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("to_wait4",       V_MS,   M_MS,  1, 10, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("halt_start",     V_IDLE, M_ALL, 0, 11, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_cycle("halt_sticky",    V_IDLE, M_ALL, 0, 11, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_cycle("halt_reset",     V_IDLE, M_ALL, 0, 11, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_cycle("restart",        V_IDLE, M_ALL, 0, 0, 0);

    // Reset during the second MEM_WAIT cycle.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("rmw_run",        V_MS,   M_MS,  1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("rmw_wait1",      V_MS,   M_MS,  1, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("rmw_reset",      V_IDLE, M_ALL, 0, 2, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_cycle("rmw_idle",       V_IDLE, M_ALL, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_cycle("rmw_start",      V_IDLE, M_ALL, 0, 0, 0);
    drive(0, 0, 0, 5, 5, 5, 0, 0, 0, 0, 0); exp_cycle("no_memread_lu",  V_RUN,  M_ALL, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("queue_drained", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
